run_controller: RTL

- Sequencer that owns the 16-bit single-cycle computer for bring-up and regression runs.
- Streams a program image into instruction memory, then holds the CPU in reset for a fixed number of cycles, then releases it and enables it.
- Watches the data-memory write port for the completion mailbox store (address 84) and freezes the CPU on it; reports pass/fail, the stored value, the cycle count and timeout.
- Sits between the top-level computer, its clock-enable input and an external loader (UART or bench driver).

---
 rtl/run_ctrl_pkg.sv | 22 ++
 rtl/sat_counter.sv | 43 ++++
 rtl/run_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run controller.
//   state_e         - session sequencer states
//   DONE_ADDR_DEF   - default completion mailbox data address
//   PASS_VALUE_DEF  - default mailbox value that means the program passed
//   HOLD_W          - width of the post-load reset-hold down-counter
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      HOLD   = 3'd2,
      RUN    = 3'd3,
      FINISH = 3'd4
   } state_e;

   localparam logic [15:0] DONE_ADDR_DEF  = 16'd84;
   localparam logic [15:0] PASS_VALUE_DEF = 16'h0096;

   // Supports HOLD_CYCLES in 1..255.
   localparam int HOLD_W = 8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
//   clk_i    - clock
//   reset_ni - synchronous active-low reset (count -> 0)
//   clr_i    - synchronous clear, wins over enable
//   en_i     - count enable
//   count_o  - registered count value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         reset_ni,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = {W{1'b0}};
      end else if (en_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/run_controller.sv
// run_controller: load/run sequencer for the 16-bit single-cycle computer.
// Streams a program into instruction memory, holds the CPU in reset for
// HOLD_CYCLES, runs it, and freezes it on the completion mailbox store.
//   clk, reset (sync, active-low), start       - control
//   load_valid/load_data/load_last/load_ready  - loader stream
//   imem_we/imem_waddr/imem_wdata              - instruction-memory write port
//   cpu_reset/cpu_en                           - CPU reset and clock enable
//   memwrite/dataadr/writedata                 - snooped CPU data-store port
//   timeout_limit                              - max RUN cycles, 0 = unlimited
//   busy/done/pass/result/cycles               - session status
//   err_timeout/err_overflow                   - error flags
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int            N           = 16,
   parameter int            IMEM_AW     = 6,
   parameter int            HOLD_CYCLES = 2,
   parameter int            TW          = 16,
   parameter logic [N-1:0]  DONE_ADDR   = N'(DONE_ADDR_DEF),
   parameter logic [N-1:0]  PASS_VALUE  = N'(PASS_VALUE_DEF)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               load_valid,
   input  logic [N-1:0]       load_data,
   input  logic               load_last,
   output logic               load_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_waddr,
   output logic [N-1:0]       imem_wdata,
   output logic               cpu_reset,
   output logic               cpu_en,
   input  logic               memwrite,
   input  logic [N-1:0]       dataadr,
   input  logic [N-1:0]       writedata,
   input  logic [TW-1:0]      timeout_limit,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [N-1:0]       result,
   output logic [TW-1:0]      cycles,
   output logic               err_timeout,
   output logic               err_overflow
);

   state_e               state_q, state_d;
   logic [IMEM_AW-1:0]   addr_q, addr_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic                 imem_we_q, imem_we_d;
   logic [IMEM_AW-1:0]   imem_waddr_q, imem_waddr_d;
   logic [N-1:0]         imem_wdata_q, imem_wdata_d;
   logic                 cpu_reset_q, cpu_reset_d;
   logic                 cpu_en_q, cpu_en_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic [N-1:0]         result_q, result_d;
   logic                 err_timeout_q, err_timeout_d;
   logic                 err_overflow_q, err_overflow_d;
   logic [TW-1:0]        cycles_s;

   logic accept_s, addr_full_s, start_take_s, run_s, hit_s, timeout_s;

   assign load_ready   = (state_q == LOAD);
   assign accept_s     = load_valid && load_ready;
   assign addr_full_s  = (addr_q == {IMEM_AW{1'b1}});
   assign start_take_s = start && ((state_q == IDLE) || (state_q == FINISH));
   assign run_s        = (state_q == RUN);
   assign hit_s        = memwrite && (dataadr == DONE_ADDR);
   // cycles still shows the previous count here, so the last allowed cycle is limit-1.
   assign timeout_s    = (timeout_limit != {TW{1'b0}}) && (cycles_s == (timeout_limit - TW'(1)));

   sat_counter #(.W(TW)) u_cycles (
      .clk_i    (clk),
      .reset_ni (reset),
      .clr_i    (start_take_s),
      .en_i     (run_s),
      .count_o  (cycles_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOAD;
            else       state_d = IDLE;
         end
         LOAD: begin
            if (accept_s && load_last)        state_d = HOLD;
            else if (accept_s && addr_full_s) state_d = FINISH;
            else                              state_d = LOAD;
         end
         HOLD: begin
            if (hold_q == {HOLD_W{1'b0}}) state_d = RUN;
            else                          state_d = HOLD;
         end
         RUN: begin
            if (hit_s || timeout_s) state_d = FINISH;
            else                    state_d = RUN;
         end
         FINISH: begin
            if (start) state_d = LOAD;
            else       state_d = FINISH;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values; CPU controls follow the next state so they line up with it.
   always_comb begin
      addr_d         = addr_q;
      imem_we_d      = 1'b0;
      imem_waddr_d   = imem_waddr_q;
      imem_wdata_d   = imem_wdata_q;
      pass_d         = pass_q;
      result_d       = result_q;
      err_timeout_d  = err_timeout_q;
      err_overflow_d = err_overflow_q;

      if (start_take_s) begin
         addr_d         = {IMEM_AW{1'b0}};
         pass_d         = 1'b0;
         result_d       = {N{1'b0}};
         err_timeout_d  = 1'b0;
         err_overflow_d = 1'b0;
      end else if (accept_s) begin
         imem_we_d    = 1'b1;
         imem_waddr_d = addr_q;
         imem_wdata_d = load_data;
         // The counter parks at the top address; a full image without last is an overflow.
         if (!addr_full_s) addr_d = addr_q + IMEM_AW'(1);
         else              addr_d = addr_q;
         if (addr_full_s && !load_last) err_overflow_d = 1'b1;
         else                           err_overflow_d = err_overflow_q;
      end else if (run_s && hit_s) begin
         result_d      = writedata;
         pass_d        = (writedata == PASS_VALUE);
         err_timeout_d = 1'b0;
      end else if (run_s && timeout_s) begin
         err_timeout_d = 1'b1;
      end else begin
         err_timeout_d = err_timeout_q;
      end

      // Reloaded throughout LOAD so HOLD always starts from a full count.
      if (state_q == LOAD) begin
         hold_d = HOLD_W'(HOLD_CYCLES - 1);
      end else if ((state_q == HOLD) && (hold_q != {HOLD_W{1'b0}})) begin
         hold_d = hold_q - HOLD_W'(1);
      end else begin
         hold_d = hold_q;
      end

      case (state_d)
         IDLE:   begin cpu_reset_d = 1'b1; cpu_en_d = 1'b0; busy_d = 1'b0; done_d = 1'b0; end
         LOAD:   begin cpu_reset_d = 1'b1; cpu_en_d = 1'b0; busy_d = 1'b1; done_d = 1'b0; end
         HOLD:   begin cpu_reset_d = 1'b1; cpu_en_d = 1'b1; busy_d = 1'b1; done_d = 1'b0; end
         RUN:    begin cpu_reset_d = 1'b0; cpu_en_d = 1'b1; busy_d = 1'b1; done_d = 1'b0; end
         // An overflowed image never ran, so the CPU stays in reset.
         FINISH: begin cpu_reset_d = err_overflow_d; cpu_en_d = 1'b0; busy_d = 1'b0; done_d = 1'b1; end
         default: begin cpu_reset_d = 1'b1; cpu_en_d = 1'b0; busy_d = 1'b0; done_d = 1'b0; end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_q         <= {IMEM_AW{1'b0}};
         hold_q         <= {HOLD_W{1'b0}};
         imem_we_q      <= 1'b0;
         imem_waddr_q   <= {IMEM_AW{1'b0}};
         imem_wdata_q   <= {N{1'b0}};
         cpu_reset_q    <= 1'b1;
         cpu_en_q       <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         result_q       <= {N{1'b0}};
         err_timeout_q  <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         addr_q         <= addr_d;
         hold_q         <= hold_d;
         imem_we_q      <= imem_we_d;
         imem_waddr_q   <= imem_waddr_d;
         imem_wdata_q   <= imem_wdata_d;
         cpu_reset_q    <= cpu_reset_d;
         cpu_en_q       <= cpu_en_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         pass_q         <= pass_d;
         result_q       <= result_d;
         err_timeout_q  <= err_timeout_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   assign imem_we      = imem_we_q;
   assign imem_waddr   = imem_waddr_q;
   assign imem_wdata   = imem_wdata_q;
   assign cpu_reset    = cpu_reset_q;
   assign cpu_en       = cpu_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign result       = result_q;
   assign cycles       = cycles_s;
   assign err_timeout  = err_timeout_q;
   assign err_overflow = err_overflow_q;

endmodule
